// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline-stage registers.
package pipe_pkg;

   // Occupancy counter width (0..2 entries).
   localparam int unsigned OCC_W = 2;

   // Field widths of the EX/MEM payload and the resulting default stage width.
   localparam int unsigned WE_W       = 1;
   localparam int unsigned W_ADDR_W   = 32;
   localparam int unsigned W_DATA_W   = 32;
   localparam int unsigned OPCODE_W   = 5;
   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned PIPE_DATA_W = WE_W + W_ADDR_W + W_DATA_W + OPCODE_W + MEM_ADDR_W;

   // Stage occupancy state; encoding equals the number of entries held.
   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   // EX/MEM payload layout carried opaquely through the default-width stage.
   typedef struct packed {
      logic                  we;
      logic [W_ADDR_W-1:0]   w_addr;
      logic [W_DATA_W-1:0]   w_data;
      logic [OPCODE_W-1:0]   opcode;
      logic [MEM_ADDR_W-1:0] mem_addr;
   } ex_mem_t;

   // Occupancy count held in a given state.
   function automatic logic [OCC_W-1:0] state_occ(input pipe_state_e st);
      return OCC_W'(st);
   endfunction

endpackage

// File: rtl/r_pipe_slot.sv
// Single payload register with load and synchronous clear.
module r_pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              load_in,
   input  logic              clr_in,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] q_out
);

   // Payload register: reset and clear zero it, load captures d_in.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         q_out <= '0;
      end else if (clr_in) begin
         q_out <= '0;
      end else if (load_in) begin
         q_out <= d_in;
      end
   end

endmodule

// File: rtl/r_pipe_skid.sv
// Pipeline-stage register with valid/ready handshake and optional skid entry.
module r_pipe_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W          = PIPE_DATA_W,
   parameter bit          SKID            = 1'b1,
   parameter bit          CLEAR_ON_BUBBLE = 1'b1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              up_valid_in,
   output logic              up_ready_out,
   input  logic [DATA_W-1:0] up_data_in,
   output logic              down_valid_out,
   input  logic              down_ready_in,
   output logic [DATA_W-1:0] down_data_out,
   output logic              busy_out,
   output logic [OCC_W-1:0]  occ_out
);

   pipe_state_e       state_q;
   pipe_state_e       state_d;
   logic              push;
   logic              pop;
   logic              main_load;
   logic              main_clr;
   logic              main_sel_skid;
   logic              skid_load;
   logic              skid_clr;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   assign push = up_valid_in & up_ready_out;
   assign pop  = down_valid_out & down_ready_in;

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: hold when disabled, flush empties, otherwise follow push/pop.
   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         if (flush_in) begin
            state_d = EMPTY;
         end else begin
            unique case (state_q)
               EMPTY: if (push) state_d = ONE;
               ONE: begin
                  if (push && !pop)      state_d = SKID ? TWO : ONE;
                  else if (!push && pop) state_d = EMPTY;
               end
               TWO:     if (pop) state_d = ONE;
               default: state_d = EMPTY;
            endcase
         end
      end
   end

   // Slot control: which slot loads or clears on this edge.
   always_comb begin
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (rdy_in) begin
         if (flush_in) begin
            main_clr = CLEAR_ON_BUBBLE;
            skid_clr = CLEAR_ON_BUBBLE;
         end else begin
            unique case (state_q)
               EMPTY: main_load = push;
               ONE: begin
                  if (push && pop)       main_load = 1'b1;
                  else if (push && !pop) skid_load = SKID;
                  else if (pop)          main_clr  = CLEAR_ON_BUBBLE;
               end
               TWO: begin
                  if (pop) begin
                     main_load     = 1'b1;
                     main_sel_skid = 1'b1;
                     skid_clr      = CLEAR_ON_BUBBLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign main_d = main_sel_skid ? skid_q : up_data_in;

   r_pipe_slot #(.DATA_W(DATA_W)) u_main (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .load_in (main_load),
      .clr_in  (main_clr),
      .d_in    (main_d),
      .q_out   (main_q)
   );

   generate
      if (SKID) begin : g_skid
         logic up_ready_q;

         r_pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .load_in (skid_load),
            .clr_in  (skid_clr),
            .d_in    (up_data_in),
            .q_out   (skid_q)
         );

         // Registered upstream ready: low only while both entries are held.
         always_ff @(posedge clk_in) begin
            if (!rst_in) begin
               up_ready_q <= 1'b1;
            end else begin
               up_ready_q <= (state_d != TWO);
            end
         end

         assign up_ready_out = up_ready_q;
         assign busy_out     = (state_q == TWO);
      end else begin : g_noskid
         logic skid_unused;

         assign skid_q       = '0;
         assign skid_unused  = skid_load | skid_clr;
         assign up_ready_out = !down_valid_out | down_ready_in;
         assign busy_out     = down_valid_out & !down_ready_in;
      end
   endgenerate

   assign down_valid_out = (state_q != EMPTY);
   assign down_data_out  = main_q;
   assign occ_out        = state_occ(state_q);

endmodule

// File: tb/tb_r_pipe_skid.sv
// Bench for r_pipe_skid: SKID=1 and SKID=0 instances against queue models.
module tb_r_pipe_skid;

   localparam int unsigned DW = 8;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, flush_in, up_valid_in, down_ready_in;
   logic [DW-1:0] up_data_in;

   logic          ready1, valid1, busy1;
   logic [DW-1:0] data1;
   logic [1:0]    occ1;
   logic          ready0, valid0, busy0;
   logic [DW-1:0] data0;
   logic [1:0]    occ0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] q1[$];
   logic [DW-1:0] q0[$];
   logic          acc1, acc0, pop1, pop0;

   always #5 clk_in = ~clk_in;

   r_pipe_skid #(.DATA_W(DW), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b1)) u_dut1 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .up_valid_in(up_valid_in), .up_ready_out(ready1), .up_data_in(up_data_in),
      .down_valid_out(valid1), .down_ready_in(down_ready_in), .down_data_out(data1),
      .busy_out(busy1), .occ_out(occ1)
   );

   r_pipe_skid #(.DATA_W(DW), .SKID(1'b0), .CLEAR_ON_BUBBLE(1'b1)) u_dut0 (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .up_valid_in(up_valid_in), .up_ready_out(ready0), .up_data_in(up_data_in),
      .down_valid_out(valid0), .down_ready_in(down_ready_in), .down_data_out(data0),
      .busy_out(busy0), .occ_out(occ0)
   );

   // Single comparison point.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Compare both instances against their models and decide this edge's moves.
   task automatic check_outs();
      logic          m_rdy1, m_rdy0;
      logic [DW-1:0] h1, h0;
      m_rdy1 = (q1.size() < 2);
      m_rdy0 = (q0.size() == 0) || down_ready_in;
      h1 = (q1.size() != 0) ? q1[0] : '0;
      h0 = (q0.size() != 0) ? q0[0] : '0;
      chk("s1_ready", 32'(ready1), 32'(m_rdy1));
      chk("s1_valid", 32'(valid1), 32'(q1.size() != 0));
      chk("s1_data",  32'(data1),  32'(h1));
      chk("s1_busy",  32'(busy1),  32'(q1.size() == 2));
      chk("s1_occ",   32'(occ1),   32'(q1.size()));
      chk("s0_ready", 32'(ready0), 32'(m_rdy0));
      chk("s0_valid", 32'(valid0), 32'(q0.size() != 0));
      chk("s0_data",  32'(data0),  32'(h0));
      chk("s0_busy",  32'(busy0),  32'((q0.size() != 0) && !down_ready_in));
      chk("s0_occ",   32'(occ0),   32'(q0.size()));
      acc1 = rst_in && rdy_in && !flush_in && up_valid_in && m_rdy1;
      acc0 = rst_in && rdy_in && !flush_in && up_valid_in && m_rdy0;
      pop1 = rst_in && rdy_in && !flush_in && down_ready_in && (q1.size() != 0);
      pop0 = rst_in && rdy_in && !flush_in && down_ready_in && (q0.size() != 0);
   endtask

   // Apply one clock edge to the models.
   task automatic model_edge();
      if (!rst_in || (rdy_in && flush_in)) begin
         q1.delete();
         q0.delete();
      end else begin
         if (pop1) void'(q1.pop_front());
         if (pop0) void'(q0.pop_front());
         if (acc1) q1.push_back(up_data_in);
         if (acc0) q0.push_back(up_data_in);
      end
   endtask

   // One cycle: check at negedge+1, clock, update model, return at next negedge.
   task automatic cycle();
      #1;
      check_outs();
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
   endtask

   // Offer one beat until the SKID=1 instance takes it (bounded).
   task automatic send(input logic [DW-1:0] d);
      up_valid_in = 1'b1;
      up_data_in  = d;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (acc1) break;
      end
      chk("send_acc", 32'(acc1), 32'd1);
      up_valid_in = 1'b0;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
      up_valid_in = 1'b1; up_data_in = 8'hAA; down_ready_in = 1'b0;
      acc1 = 1'b0; acc0 = 1'b0; pop1 = 1'b0; pop0 = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);

      // Reset with upstream offering 0xAA.
      for (int i = 0; i < 2; i++) cycle();
      rst_in = 1'b1;
      up_valid_in = 1'b0;
      #1;
      chk("rst_ready", 32'(ready1), 32'd1);
      chk("rst_occ",   32'(occ1),   32'd0);
      @(negedge clk_in);

      // Streaming with downstream always ready.
      down_ready_in = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         up_valid_in = 1'b1;
         up_data_in  = DW'(i);
         cycle();
      end
      up_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Skid fill: third beat must be refused.
      down_ready_in = 1'b0;
      send(8'h11);
      send(8'h22);
      up_valid_in = 1'b1;
      up_data_in  = 8'h33;
      cycle();
      chk("skid_occ",  32'(occ1),   32'd2);
      chk("skid_busy", 32'(busy1),  32'd1);
      chk("skid_rdy",  32'(ready1), 32'd0);
      chk("skid_head", 32'(data1),  32'h11);
      down_ready_in = 1'b1;
      send(8'h33);
      for (int i = 0; i < 4; i++) cycle();

      // Flush while full, with a beat offered.
      down_ready_in = 1'b0;
      send(8'h01);
      send(8'h02);
      up_valid_in = 1'b1;
      up_data_in  = 8'h44;
      flush_in    = 1'b1;
      cycle();
      flush_in    = 1'b0;
      up_valid_in = 1'b0;
      #1;
      chk("flush_occ",  32'(occ1),   32'd0);
      chk("flush_vld",  32'(valid1), 32'd0);
      chk("flush_data", 32'(data1),  32'd0);
      @(negedge clk_in);
      cycle();

      // Disabled stage ignores flush and pop.
      send(8'h55);
      rdy_in = 1'b0; flush_in = 1'b1; down_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      rdy_in = 1'b1; flush_in = 1'b0; down_ready_in = 1'b0;
      #1;
      chk("hold_vld",  32'(valid1), 32'd1);
      chk("hold_data", 32'(data1),  32'h55);
      @(negedge clk_in);
      down_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Toggling downstream ready against a continuous source.
      for (int i = 0; i < 12; i++) begin
         up_valid_in   = 1'b1;
         up_data_in    = DW'(8'h60 + i);
         down_ready_in = (i % 2 == 0);
         cycle();
      end
      up_valid_in = 1'b0;
      down_ready_in = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         rst_in        = ($urandom_range(0, 99) != 0);
         rdy_in        = ($urandom_range(0, 7) != 0);
         flush_in      = ($urandom_range(0, 19) == 0);
         up_valid_in   = ($urandom_range(0, 3) != 0);
         down_ready_in = ($urandom_range(0, 2) != 0);
         up_data_in    = DW'($urandom);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
